// File: rtl/i2c_write24_master.sv
// I2C three-byte write master: START, 3 x (8 data bits + ACK slot), STOP, with a GO/END handshake.
// Optional build macro I2C_NACK_ABORT_EN: a NACKed byte ends the transfer with an immediate STOP.
module i2c_write24_master #(
    parameter int QTR_CYC = 1
) (
    input  logic        clk_i2c,
    input  logic        reset,
    input  logic [23:0] i2c_data,
    input  logic        i2c_go,
    output logic        i2c_end,
    output logic [2:0]  i2c_ack,
    output logic        busy,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    localparam int QW = (QTR_CYC > 1) ? $clog2(QTR_CYC) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QTR_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state, state_d;
    logic [QW-1:0] qcnt, qcnt_d;
    logic [1:0]  qph, qph_d;
    logic [2:0]  bit_idx, bit_d;
    logic [1:0]  byte_idx, byte_d;
    logic [23:0] shift_q, shift_d;
    logic [2:0]  ack_q, ack_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;
    logic        sda_in;
    logic        q_wrap, q_end, in_xfer, nack_stop;

    assign sda_in   = I2C_SDAT;
    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
    assign I2C_SCLK = scl_q;
    assign i2c_ack  = ack_q;
    assign i2c_end  = (state == S_DONE);
    assign busy     = in_xfer;

    assign in_xfer = (state == S_START) || (state == S_BIT) ||
                     (state == S_ACK)   || (state == S_STOP);
    assign q_wrap  = (qcnt == QLAST);
    assign q_end   = q_wrap && (qph == 2'd3);

`ifdef I2C_NACK_ABORT_EN
    // The ACK bit for the current byte was captured one quarter earlier (end of q2).
    assign nack_stop = ack_q[2'd2 - byte_idx];
`else
    assign nack_stop = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        qcnt_d   = qcnt;
        qph_d    = qph;
        bit_d    = bit_idx;
        byte_d   = byte_idx;
        shift_d  = shift_q;
        ack_d    = ack_q;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;

        if (in_xfer) begin
            qcnt_d = q_wrap ? '0 : qcnt + 1'b1;
            if (q_wrap) begin
                qph_d = qph + 2'd1;
            end
        end

        case (state)
            S_IDLE: begin
                if (i2c_go) begin
                    shift_d = i2c_data;
                    ack_d   = 3'b111;
                    qcnt_d  = '0;
                    qph_d   = 2'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (q_end) begin
                    bit_d   = 3'd7;
                    byte_d  = 2'd0;
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                if (q_end) begin
                    shift_d = {shift_q[22:0], 1'b0};
                    if (bit_idx == 3'd0) begin
                        state_d = S_ACK;
                    end else begin
                        bit_d = bit_idx - 3'd1;
                    end
                end
            end
            S_ACK: begin
                if (q_wrap && (qph == 2'd2)) begin
                    ack_d[2'd2 - byte_idx] = sda_in;
                end
                if (q_end) begin
                    if ((byte_idx == 2'd2) || nack_stop) begin
                        state_d = S_STOP;
                    end else begin
                        byte_d  = byte_idx + 2'd1;
                        bit_d   = 3'd7;
                        state_d = S_BIT;
                    end
                end
            end
            S_STOP: begin
                if (q_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!i2c_go) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus levels are decoded from the next state so they come straight off flops.
        case (state_d)
            S_START: begin
                scl_d    = ~qph_d[1];
                sda_oe_d = 1'b1;
            end
            S_BIT: begin
                scl_d    = qph_d[1];
                sda_oe_d = ~shift_d[23];
            end
            S_ACK: begin
                scl_d    = qph_d[1];
                sda_oe_d = 1'b0;
            end
            S_STOP: begin
                scl_d    = (qph_d != 2'd0);
                sda_oe_d = (qph_d != 2'd3);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i2c) begin
        if (reset) begin
            state    <= S_IDLE;
            qcnt     <= '0;
            qph      <= 2'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            ack_q    <= 3'b111;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
        end else begin
            state    <= state_d;
            qcnt     <= qcnt_d;
            qph      <= qph_d;
            bit_idx  <= bit_d;
            byte_idx <= byte_d;
            ack_q    <= ack_d;
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    always_ff @(posedge clk_i2c) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_i2c_write24_master.sv
// Scoreboard bench: two masters (QTR_CYC=1 and 3), each with a behavioural ACK/NACK slave and bus monitor.
module tb_i2c_write24_master;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] bits;
        int          nbits;
        logic [2:0]  ack;
        int          lat;
    } exp_t;

    function automatic void check(string name, longint act, longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Reference: the bus carries each sent byte MSB first followed by the slave's ACK bit.
    function automatic exp_t model(logic [23:0] d, logic [2:0] nack, int q);
        exp_t e;
        int   n;
        logic stop;
        e.bits = '0;
        e.ack  = 3'b111;
        n      = 0;
        stop   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!stop) begin
                e.bits       = (e.bits << 9) | (32'(d[23-8*i -: 8]) << 1) | 32'(nack[i]);
                e.ack[2-i]   = nack[i];
                n++;
`ifdef I2C_NACK_ABORT_EN
                if (nack[i]) stop = 1'b1;
`endif
            end
        end
        e.nbits = 9 * n;
        e.lat   = (8 + 36 * n) * q;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int Q = (g == 0) ? 1 : 3;

        logic        rst   = 1'b1;
        logic        go    = 1'b0;
        logic [23:0] data  = '0;
        logic        endo;
        logic        busy;
        logic [2:0]  ack;
        logic        scl;
        wire         sda;
        logic        sda_b;
        logic        slv_drv = 1'b0;
        logic [2:0]  nack    = '0;
        logic        done_f  = 1'b0;
        exp_t        exp_q[$];

        assign sda   = slv_drv ? 1'b0 : 1'bz;
        pullup (sda);
        assign sda_b = (sda !== 1'b0);

        i2c_write24_master #(.QTR_CYC(Q)) dut (
            .clk_i2c (clk),
            .reset   (rst),
            .i2c_data(data),
            .i2c_go  (go),
            .i2c_end (endo),
            .i2c_ack (ack),
            .busy    (busy),
            .I2C_SCLK(scl),
            .I2C_SDAT(sda)
        );

        // Slave: watches START/STOP and SCL edges, pulls SDA low in the ACK slot unless told to NACK.
        logic s_pscl = 1'b1, s_psda = 1'b1, s_inx = 1'b0;
        int   s_rc   = 0;
        initial forever begin
            logic cur;
            int   bi;
            @(negedge clk);
            cur = sda_b;
            if (scl && s_pscl && s_psda && !cur) begin
                s_inx = 1'b1; s_rc = 0; slv_drv = 1'b0;
            end else if (scl && s_pscl && !s_psda && cur) begin
                s_inx = 1'b0; slv_drv = 1'b0;
            end else if (s_inx) begin
                if (scl && !s_pscl) s_rc++;
                else if (!scl && s_pscl) begin
                    bi = s_rc / 9;
                    slv_drv = 1'b0;
                    if ((s_rc % 9 == 8) && (bi < 3)) slv_drv = !nack[bi];
                end
            end
            s_pscl = scl;
            s_psda = cur;
        end

        // Monitor: collects bits on SCL rises, pulse widths and SDA-while-SCL-high changes.
        logic        m_pscl = 1'b1, m_psda = 1'b1, m_pbusy = 1'b0, m_pend = 1'b0, m_hv = 1'b0;
        int          m_start = 0, m_rises = 0, m_hi = 0, m_badw = 0, m_hs = 0;
        logic [31:0] m_bits = '0;
        initial forever begin
            exp_t e;
            @(negedge clk);
            if (busy && !m_pbusy) begin
                m_start = cyc; m_rises = 0; m_badw = 0; m_hs = 0; m_bits = '0; m_hv = 1'b0;
            end
            if (scl && m_pscl && (sda_b != m_psda)) m_hs++;
            if (scl && !m_pscl) begin
                m_rises++; m_bits = {m_bits[30:0], sda_b}; m_hi = 1; m_hv = 1'b1;
            end else if (scl) begin
                m_hi++;
            end else if (m_pscl && m_hv) begin
                if (m_hi != 2 * Q) m_badw++;
            end
            if (endo && !m_pend) begin
                if (exp_q.size() == 0) begin
                    check("end_without_expect", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("latency",      cyc - m_start, e.lat);
                    check("ack",          ack, e.ack);
                    check("scl_pulses",   m_rises - 1, e.nbits);
                    check("sda_bits",     m_bits >> 1, e.bits);
                    check("sda_hi_moves", m_hs, 2);
                    check("scl_hi_width", m_badw, 0);
                    check("busy_at_end",  busy, 0);
                end
            end
            m_pscl  = scl;
            m_psda  = sda_b;
            m_pbusy = busy;
            m_pend  = endo;
        end

        task automatic check_idle(string tag);
            check({tag, "_scl"},  scl, 1);
            check({tag, "_sda"},  sda_b, 1);
            check({tag, "_end"},  endo, 0);
            check({tag, "_ack"},  ack, 3'b111);
            check({tag, "_busy"}, busy, 0);
        endtask

        task automatic xfer(input logic [23:0] d, input logic [2:0] nk, input int drop_after);
            logic got;
            data = d;
            nack = nk;
            exp_q.push_back(model(d, nk, Q));
            go  = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 200 * Q; i++) begin
                @(negedge clk);
                if (i == 0) check("start_next_edge", busy, 1);
                if (i == 1) data = 24'($urandom);
                if (i == drop_after) go = 1'b0;
                if (endo) begin
                    got = 1'b1;
                    break;
                end
            end
            check("end_seen", got, 1);
            go = 1'b0;
            @(negedge clk);
            check("end_clear", endo, 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        endtask

        initial begin
            exp_t e;
            int   bcnt;
            repeat (3) @(negedge clk);
            check_idle("reset");
            rst = 1'b0;
            @(negedge clk);

            xfer(24'h34_1E_00, 3'b000, -1);
            xfer(24'h34_0C_00, 3'b010, -1);

            // GO held high long after completion: END stays up, no retrigger.
            e    = model(24'h34_1E_00, 3'b000, Q);
            data = 24'h34_1E_00;
            nack = 3'b000;
            exp_q.push_back(e);
            go   = 1'b1;
            bcnt = 0;
            repeat (e.lat + 184) begin
                @(negedge clk);
                if (busy) bcnt++;
            end
            check("hold_end",   endo, 1);
            check("hold_busy",  bcnt, e.lat);
            check("hold_ack",   ack, e.ack);
            go = 1'b0;
            @(negedge clk);
            check("hold_release", endo, 0);
            xfer(24'h1A_5A_C3, 3'b000, -1);

            // Reset in the middle of byte 1, bit 4.
            data = 24'h34_1E_00;
            nack = 3'b000;
            go   = 1'b1;
            repeat (54 * Q) @(negedge clk);
            check("mid_ack", ack, 3'b011);
            rst = 1'b1;
            go  = 1'b0;
            @(negedge clk);
            check_idle("midrst");
            rst = 1'b0;
            repeat (2) @(negedge clk);
            xfer(24'h34_1E_00, 3'b000, -1);

            repeat (g == 0 ? 24 : 6) begin
                logic [23:0] d;
                logic [2:0]  nk;
                int          drop;
                d    = 24'($urandom);
                nk   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 100 * Q)) : -1;
                xfer(d, nk, drop);
            end
            check("queue_drained", exp_q.size(), 0);
            done_f = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 90000; i++) begin
            @(negedge clk);
            if (u[0].done_f && u[1].done_f) break;
        end
        if (!(u[0].done_f && u[1].done_f)) check("all_done", {u[1].done_f, u[0].done_f}, 2'b11);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
